// File: rtl/ioctl_slot_loader.sv
// Packs the data_io download byte stream into DATA_W words and writes them into one of
// SLOTS SDRAM regions through a req/ack port, tracking per-slot presence and errors.
module ioctl_slot_loader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 25,
    parameter int SLOTS      = 4,
    parameter int SLOT_SHIFT = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [SLOTS-1:0]    eject,
    output logic [SLOTS-1:0]    present,
    output logic                busy,
    output logic                overflow,
    output logic [24:0]         last_size
);
    localparam int BYTES    = DATA_W / 8;
    localparam int LANE_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SLOT_LOG = $clog2(SLOTS);
    localparam int SLOT_W   = (SLOTS > 1) ? SLOT_LOG : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W    = ADDR_W + DATA_W + BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_r;
    logic                dl_prev_r;
    logic [SLOT_W-1:0]   slot_r;
    logic                overflow_r;
    logic [24:0]         size_r;
    logic [24:0]         last_size_r;
    logic [SLOTS-1:0]    present_r;
    logic [DATA_W-1:0]   pack_data_r;
    logic [BYTES-1:0]    pack_be_r;
    logic [24:0]         pack_addr_r;
    logic [ENT_W-1:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                mem_req_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_din_r;
    logic [BYTES-1:0]    mem_be_r;

    logic                rise_s, fall_s, idx_ok_s, in_range_s, top_s, load_wr_s, keep_s;
    logic [LANE_W-1:0]   lane_s;
    logic [24:0]         word_s;
    logic [ADDR_W-1:0]   slot_base_s;
    logic [DATA_W-1:0]   new_data_s;
    logic [BYTES-1:0]    new_be_s;
    logic                push_a_v_s, push_b_v_s, acc_a_s, acc_b_s;
    logic [ENT_W-1:0]    ent_a_s, ent_b_s;
    logic [CNT_W-1:0]    space_s;
    logic                drop_s, pop_s, done_s, ok_s;
    logic [SLOTS-1:0]    present_next_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rise_s      = ioctl_download & ~dl_prev_r;
    assign fall_s      = ~ioctl_download & dl_prev_r;
    assign idx_ok_s    = (ioctl_index >> SLOT_LOG) == 8'd0;
    assign in_range_s  = (ioctl_addr >> SLOT_SHIFT) == 25'd0;
    assign lane_s      = LANE_W'(ioctl_addr & 25'(BYTES - 1));
    assign word_s      = ioctl_addr & ~25'(BYTES - 1);
    assign top_s       = lane_s == LANE_W'(BYTES - 1);
    assign slot_base_s = ADDR_W'(slot_r) << SLOT_SHIFT;
    assign load_wr_s   = (state_r == ST_LOAD) && ioctl_wr && in_range_s;
    assign keep_s      = (pack_be_r != '0) && (pack_addr_r == word_s);

    // Merge the incoming byte into the pack word and decide the up-to-two FIFO pushes.
    always_comb begin
        new_data_s = '0;
        new_be_s   = '0;
        for (int i = 0; i < BYTES; i++) begin
            new_data_s[8*i +: 8] = (lane_s == LANE_W'(i)) ? ioctl_dout
                                 : (keep_s ? pack_data_r[8*i +: 8] : 8'h00);
            new_be_s[i]          = (lane_s == LANE_W'(i)) ? 1'b1 : (keep_s & pack_be_r[i]);
        end
        push_a_v_s = ((load_wr_s && !keep_s) || (state_r == ST_FLUSH)) && (pack_be_r != '0);
        push_b_v_s = load_wr_s && top_s;
        ent_a_s    = {slot_base_s + ADDR_W'(pack_addr_r), pack_data_r, pack_be_r};
        ent_b_s    = {slot_base_s + ADDR_W'(word_s), new_data_s, new_be_s};
        space_s    = CNT_W'(FIFO_DEPTH) - count_r;
        acc_a_s    = push_a_v_s && (space_s != '0);
        acc_b_s    = push_b_v_s && (space_s > (acc_a_s ? CNT_W'(1) : CNT_W'(0)));
        drop_s     = (push_a_v_s && !acc_a_s) || (push_b_v_s && !acc_b_s)
                   || ((state_r == ST_LOAD) && ioctl_wr && !in_range_s)
                   || (((state_r == ST_FLUSH) || (state_r == ST_DRAIN)) && ioctl_wr);
        pop_s      = (count_r != '0) && !mem_req_r;
        done_s     = (state_r == ST_DRAIN) && (count_r == '0) && !mem_req_r;
        ok_s       = (size_r != 25'd0) && !(overflow_r | drop_s);
        // Completion of the active slot overrides a coincident eject.
        for (int i = 0; i < SLOTS; i++) begin
            present_next_s[i] = (done_s && (slot_r == SLOT_W'(i))) ? ok_s
                              : (present_r[i] & ~eject[i]);
        end
    end

    // FIFO storage: no reset needed, validity is tracked by the pointers and count.
    always_ff @(posedge clk_sys) begin
        if (acc_a_s) begin
            fifo_mem_r[wr_ptr_r] <= ent_a_s;
        end
        if (acc_b_s) begin
            fifo_mem_r[acc_a_s ? ptr_inc(wr_ptr_r) : wr_ptr_r] <= ent_b_s;
        end
    end

    // Control FSM, packing, FIFO bookkeeping and memory request port.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            dl_prev_r   <= 1'b0;
            slot_r      <= '0;
            overflow_r  <= 1'b0;
            size_r      <= 25'd0;
            last_size_r <= 25'd0;
            present_r   <= '0;
            pack_data_r <= '0;
            pack_be_r   <= '0;
            pack_addr_r <= 25'd0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_din_r   <= '0;
            mem_be_r    <= '0;
        end else begin
            dl_prev_r  <= ioctl_download;
            present_r  <= present_next_s;
            overflow_r <= ((state_r == ST_IDLE) && rise_s && idx_ok_s) ? 1'b0
                        : (overflow_r | drop_s);
            case (state_r)
                ST_IDLE: begin
                    if (rise_s && idx_ok_s) begin
                        state_r     <= ST_LOAD;
                        slot_r      <= SLOT_W'(ioctl_index);
                        size_r      <= 25'd0;
                        pack_data_r <= '0;
                        pack_be_r   <= '0;
                        pack_addr_r <= 25'd0;
                    end
                end
                ST_LOAD: begin
                    if (load_wr_s) begin
                        pack_data_r <= top_s ? '0 : new_data_s;
                        pack_be_r   <= top_s ? '0 : new_be_s;
                        pack_addr_r <= word_s;
                        if ((ioctl_addr + 25'd1) > size_r) begin
                            size_r <= ioctl_addr + 25'd1;
                        end
                    end
                    if (fall_s) begin
                        state_r <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    pack_data_r <= '0;
                    pack_be_r   <= '0;
                    state_r     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (done_s) begin
                        state_r     <= ST_IDLE;
                        last_size_r <= size_r;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            wr_ptr_r <= (acc_a_s && acc_b_s) ? ptr_inc(ptr_inc(wr_ptr_r))
                      : ((acc_a_s || acc_b_s) ? ptr_inc(wr_ptr_r) : wr_ptr_r);
            count_r  <= count_r + CNT_W'(acc_a_s) + CNT_W'(acc_b_s) - CNT_W'(pop_s);
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
                mem_req_r <= 1'b1;
                {mem_addr_r, mem_din_r, mem_be_r} <= fifo_mem_r[rd_ptr_r];
            end else if (mem_req_r && mem_ack) begin
                mem_req_r <= 1'b0;
            end
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign mem_din   = mem_din_r;
    assign mem_be    = mem_be_r;
    assign present   = present_r;
    assign overflow  = overflow_r;
    assign last_size = last_size_r;
    assign busy      = (state_r != ST_IDLE) | (count_r != '0) | mem_req_r;
endmodule

// File: tb/tb_ioctl_slot_loader.sv
// Scoreboard bench: a 16-bit instance for the main scenarios and a 32-bit instance
// for the non-sequential byte lane case.
module tb_ioctl_slot_loader;
    typedef struct packed {
        logic [24:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, dl_a, dl_b, ioctl_wr;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;

    logic        a_req, a_rack, man_ack, a_ack, a_busy, a_ovf;
    logic [24:0] a_addr, a_size;
    logic [15:0] a_din;
    logic [1:0]  a_be;
    logic [3:0]  a_eject, a_present;

    logic        b_req, b_ack, b_busy, b_ovf;
    logic [24:0] b_addr, b_size;
    logic [31:0] b_din;
    logic [3:0]  b_be, b_eject, b_present;

    int  total = 0;
    int  bad = 0;
    int  a_delay = 2;
    bit  resp_en = 1'b1;
    bit  sel_b = 1'b0;
    wr_t q_a[$];
    wr_t q_b[$];

    assign a_ack = a_rack | man_ack;

    ioctl_slot_loader #(.DATA_W(16)) dut_a (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl_a), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .mem_req(a_req), .mem_addr(a_addr), .mem_din(a_din), .mem_be(a_be), .mem_ack(a_ack),
        .eject(a_eject), .present(a_present), .busy(a_busy), .overflow(a_ovf),
        .last_size(a_size)
    );

    ioctl_slot_loader #(.DATA_W(32)) dut_b (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl_b), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .mem_req(b_req), .mem_addr(b_addr), .mem_din(b_din), .mem_be(b_be), .mem_ack(b_ack),
        .eject(b_eject), .present(b_present), .busy(b_busy), .overflow(b_ovf),
        .last_size(b_size)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        if (sel_b) dl_b = 1'b1;
        else dl_a = 1'b1;
        tick();
    endtask

    task automatic wr_byte(input logic [24:0] addr, input logic [7:0] d);
        ioctl_addr = addr;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic end_dl();
        dl_a = 1'b0;
        dl_b = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((a_busy || b_busy) && n < budget) begin
            tick();
            n++;
        end
        if (a_busy || b_busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Ack responders: instance A with a programmable delay, instance B after one cycle.
    initial begin
        int w = 0;
        a_rack = 1'b0;
        forever begin
            @(negedge clk);
            if (a_req === 1'b1 && !a_rack && resp_en) begin
                if (w >= a_delay) begin
                    a_rack = 1'b1;
                    w = 0;
                end else w++;
            end else begin
                a_rack = 1'b0;
                if (a_req !== 1'b1) w = 0;
            end
        end
    end

    initial begin
        b_ack = 1'b0;
        forever begin
            @(negedge clk);
            b_ack = (b_req === 1'b1) && !b_ack;
        end
    end

    // Monitors: each new request is checked against the head of its scoreboard queue.
    initial begin
        logic req_d = 1'b0;
        wr_t  e;
        forever begin
            @(negedge clk);
            if (a_req === 1'b1 && req_d !== 1'b1) begin
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL memwr_a: unexpected request addr=%0h din=%0h", a_addr, a_din);
                end else begin
                    e = q_a.pop_front();
                    chk("memwr_a", {a_addr, 16'h0000, a_din, 2'b00, a_be}, e);
                end
            end
            req_d = a_req;
        end
    end

    initial begin
        logic req_d = 1'b0;
        wr_t  e;
        forever begin
            @(negedge clk);
            if (b_req === 1'b1 && req_d !== 1'b1) begin
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL memwr_b: unexpected request addr=%0h din=%0h", b_addr, b_din);
                end else begin
                    e = q_b.pop_front();
                    chk("memwr_b", {b_addr, b_din, b_be}, e);
                end
            end
            req_d = b_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n = 1'b0; dl_a = 1'b0; dl_b = 1'b0; ioctl_wr = 1'b0;
        ioctl_index = 8'd0; ioctl_dout = 8'd0; ioctl_addr = 25'd0;
        man_ack = 1'b0; a_eject = 4'd0; b_eject = 4'd0;
        tick(); tick();
        chk("rst_req", a_req, 1'b0);
        chk("rst_addr", a_addr, 25'd0);
        chk("rst_present", a_present, 4'd0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_ovf_size", {a_ovf, a_size}, 26'd0);
        reset_n = 1'b1;
        tick();

        // Three bytes into slot 1
        q_a.push_back({25'h100000, 32'h2211, 4'b0011});
        q_a.push_back({25'h100002, 32'h0033, 4'b0001});
        start_dl(8'd1);
        wr_byte(25'd0, 8'h11); wr_byte(25'd1, 8'h22); wr_byte(25'd2, 8'h33);
        end_dl();
        wait_idle(100);
        chk("t1_present", a_present, 4'b0010);
        chk("t1_size", a_size, 25'd3);
        chk("t1_ovf", a_ovf, 1'b0);

        // Ack withheld: five words fit, the sixth overflows
        a_delay = 20;
        for (int k = 0; k < 5; k++) begin
            q_a.push_back({25'h200000 + 25'(2 * k), 16'h0000, 8'(8'h41 + 2 * k), 8'(8'h40 + 2 * k),
                           4'b0011});
        end
        start_dl(8'd2);
        for (int i = 0; i < 12; i++) wr_byte(25'(i), 8'(8'h40 + i));
        end_dl();
        chk("t2_ovf_early", a_ovf, 1'b1);
        wait_idle(400);
        chk("t2_ovf", a_ovf, 1'b1);
        chk("t2_present", a_present, 4'b0010);
        chk("t2_size", a_size, 25'd12);

        // Out-of-range index is ignored entirely
        a_delay = 2;
        start_dl(8'd5);
        chk("t3_busy0", a_busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wr_byte(25'(i), 8'hEE);
            chk("t3_busy", a_busy, 1'b0);
        end
        end_dl();
        tick(); tick();
        chk("t3_busy_end", a_busy, 1'b0);
        chk("t3_present", a_present, 4'b0010);

        // Eject coincident with slot 0 completion loses; eject alone clears
        a_delay = 1;
        q_a.push_back({25'h000000, 32'h5AA5, 4'b0011});
        start_dl(8'd0);
        wr_byte(25'd0, 8'hA5); wr_byte(25'd1, 8'h5A);
        end_dl();
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!(a_req && a_rack) && n < 50);
        if (n >= 50) chk("t4_ack_timeout", 64'd1, 64'd0);
        tick();
        a_eject = 4'b0001;
        tick();
        a_eject = 4'b0000;
        chk("t4_present_kept", a_present, 4'b0011);
        chk("t4_busy", a_busy, 1'b0);
        a_eject = 4'b0001;
        tick();
        a_eject = 4'b0000;
        chk("t4_present_ejected", a_present, 4'b0010);

        // Reset with a request outstanding, then a stale ack
        resp_en = 1'b0;
        q_a.push_back({25'h300000, 32'h8877, 4'b0011});
        start_dl(8'd3);
        wr_byte(25'd0, 8'h77); wr_byte(25'd1, 8'h88);
        end_dl();
        n = 0;
        while (a_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_req_seen", a_req, 1'b1);
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("t5_req", a_req, 1'b0);
        chk("t5_busy", a_busy, 1'b0);
        chk("t5_present", a_present, 4'd0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("t5_stale_req", a_req, 1'b0);
        chk("t5_stale_busy", a_busy, 1'b0);
        chk("t5_stale_state", {a_present, a_ovf, a_size}, 30'd0);
        resp_en = 1'b1;

        // 32-bit instance: addresses 0, 5, 1 give three single-lane writes
        sel_b = 1'b1;
        q_b.push_back({25'h0, 32'h00000011, 4'b0001});
        q_b.push_back({25'h4, 32'h00005500, 4'b0010});
        q_b.push_back({25'h0, 32'h00002200, 4'b0010});
        start_dl(8'd0);
        wr_byte(25'd0, 8'h11); wr_byte(25'd5, 8'h55); wr_byte(25'd1, 8'h22);
        end_dl();
        wait_idle(100);
        sel_b = 1'b0;
        chk("t6_present", b_present, 4'b0001);
        chk("t6_size", b_size, 25'd6);
        chk("t6_ovf", b_ovf, 1'b0);

        tick(); tick();
        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ioctl_slot_loader.md
Name: ioctl_slot_loader

Overview:
- Parametrised successor to the single-flag cartridge download logic in the top level.
- Takes the data_io byte stream (ioctl_*) and packs bytes into DATA_W-bit words.
- Routes each download to one of SLOTS memory regions and writes the words to SDRAM through a req/ack port, with a small FIFO to absorb SDRAM latency.
- Keeps per-slot present flags, with per-slot eject, and a transfer size and error status for the core.

Parameters:
- DATA_W, 16, memory word width; 8, 16 or 32.
- ADDR_W, 25, memory byte-address width.
- SLOTS, 4, number of load regions; power of 2, at most 8.
- SLOT_SHIFT, 20, log2 of the byte size of one region; slot base = slot << SLOT_SHIFT.
- FIFO_DEPTH, 4, pending-word FIFO entries; power of 2.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous reset, active low.
- ioctl_download  in  1  download active, from data_io.
- ioctl_index  in  8  download index; the low log2(SLOTS) bits select the slot.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte offset within the download.
- ioctl_dout  in  8  byte data.
- mem_req  out  1  write request; held until ack.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_din  out  DATA_W  write data.
- mem_be  out  DATA_W/8  byte enables.
- mem_ack  in  1  one-cycle completion pulse.
- eject  in  SLOTS  per-slot clear pulse.
- present  out  SLOTS  slot holds a complete image.
- busy  out  1  load or drain in progress.
- overflow  out  1  sticky error for the current or last download.
- last_size  out  25  bytes in the last completed download.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE; FIFO emptied; pack register cleared.
  - mem_req=0, mem_addr=0, mem_din=0, mem_be=0.
  - present=0, busy=0, overflow=0, last_size=0.
  - A reset mid-transfer abandons the outstanding request immediately; a later mem_ack is ignored.
- Download edges are detected against the previous-cycle value of ioctl_download.
- State machine: IDLE, LOAD, FLUSH, DRAIN.
  - IDLE->LOAD on a rising edge of ioctl_download with ioctl_index[7:log2(SLOTS)]==0. Captures slot, clears overflow, size counter and pack register.
  - A rising edge with an out-of-range index stays in IDLE; all bytes of that download are ignored and present is untouched.
  - LOAD->FLUSH on a falling edge of ioctl_download.
  - FLUSH lasts 1 cycle: pushes the partial pack word if any byte enable is set, then goes to DRAIN.
  - DRAIN->IDLE when the FIFO is empty and mem_req=0. On that cycle: last_size is updated; present[slot] is set if size>0 and overflow=0, otherwise it is cleared.
- Packing (LOAD, ioctl_wr=1):
  - lane = ioctl_addr[log2(DATA_W/8)-1:0]; word address W = ioctl_addr with the lane bits zeroed.
  - If the pack register holds bytes for a different word, that word is pushed first, in the same cycle, and packing restarts.
  - The byte goes to bits [8*lane+7:8*lane] and be[lane] is set.
  - When lane is the top lane, the word is pushed in that cycle.
  - size counter = max(size, ioctl_addr+1).
  - DATA_W=8 means every byte is pushed directly.
- FIFO entry = {slot base + W, data, be}.
  - A push when the FIFO is full drops the word and sets overflow.
  - ioctl_addr >= 2^SLOT_SHIFT drops the byte and sets overflow.
  - ioctl_wr while in FLUSH or DRAIN drops the byte and sets overflow.
- Memory handshake:
  - When the FIFO is non-empty and mem_req=0, the head is popped to mem_addr/din/be and mem_req=1 next cycle.
  - mem_req and all its fields are stable until the cycle mem_ack=1 is sampled; mem_req=0 the following cycle.
  - At most one request is outstanding; minimum gap between requests is 1 idle cycle.
  - mem_ack while mem_req=0 is ignored.
  - A push and a pop in the same cycle are both honoured.
- eject[i]=1 clears present[i].
  - Simultaneous with the DRAIN->IDLE completion of slot i: completion wins.
  - eject of the slot currently loading clears it, and completion may set it again.
- busy = (state!=IDLE) | FIFO non-empty | mem_req.
- overflow holds until the next valid LOAD entry.

Test Plan:
- DATA_W=16, SLOTS=4, SLOT_SHIFT=20:
  - Download index 1 of bytes 0x11,0x22,0x33 at addr 0..2, ack 2 cycles after each req.
  - Expect mem writes (0x100000, 0x2211, be=11) then (0x100002, 0x0033, be=01).
  - Expect present=0010, last_size=3, overflow=0.
- Ack withheld 20 cycles with FIFO_DEPTH=4 while 12 bytes stream back-to-back:
  - Expect 6 words; the first 5 are queued (1 in flight plus 4 in the FIFO) and word 6 is dropped; overflow=1.
  - At completion present[slot] stays 0.
- Download index 5 with SLOTS=4: expect no mem_req, present unchanged, busy=0 throughout.
- eject=0001 pulsed in the same cycle as slot 0 completion: expect present[0]=1. A subsequent eject=0001 alone gives present[0]=0.
- reset_n=0 while mem_req=1, then a mem_ack arrives after reset:
  - Expect mem_req=0, FIFO empty, present=0, state IDLE.
  - The stale ack causes no change.
- Non-sequential addresses 0, 5, 1 with DATA_W=32:
  - Expect 3 separate writes, each with a single byte enable: 0x0 be=0001, 0x4 be=0010, 0x0 be=0010.
